if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline, feeding the decode stage directly. It owns the fetch PC, runs a single-outstanding request/grant/response handshake to instruction memory, and buffers one returned word when decode is stalled. It holds the IF/ID pipeline register (`pc_o`, `inst_o`) and applies branch/jump redirects from decode with MIPS branch-delay-slot semantics.

---
 rtl/if_stage_pkg.sv | 33 +++
 rtl/if_stage_if_id_reg.sv | 43 ++++
 rtl/if_stage.sv | 144 ++++++++++++++
 tb/tb_if_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
//==============================================================================
// Module      : if_stage_pkg
// Description : Shared constants, FSM encodings and types for the IF stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package if_stage_pkg;

    localparam logic c_RST_ENABLE    = 1'b0;
    localparam int   c_INST_ADDR_BUS = 32;
    localparam int   c_INST_BUS      = 32;

    localparam logic [c_INST_BUS-1:0] c_ZERO_WORD = 32'h0000_0000;
    localparam logic [c_INST_BUS-1:0] c_NOP_INST  = 32'h0000_0000;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_REQ  = 2'd1;
    localparam logic [1:0] c_S_WAIT = 2'd2;
    localparam logic [1:0] c_S_HOLD = 2'd3;

    typedef struct packed {
        logic [c_INST_ADDR_BUS-1:0] pc;
        logic [c_INST_BUS-1:0]      inst;
    } if_word_t;

    function automatic logic [c_INST_ADDR_BUS-1:0] align_word(input logic [c_INST_ADDR_BUS-1:0] a);
        return {a[c_INST_ADDR_BUS-1:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_stage_if_id_reg.sv
//==============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with load enable and bubble insert.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module if_id_reg
    import if_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_load,
    input  logic                       i_bubble,
    input  if_word_t                   i_word,
    output logic [c_INST_ADDR_BUS-1:0] o_pc,
    output logic [c_INST_BUS-1:0]      o_inst
);

    logic [c_INST_ADDR_BUS-1:0] r_pc;
    logic [c_INST_BUS-1:0]      r_inst;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == c_RST_ENABLE) begin
            r_pc   <= c_ZERO_WORD;
            r_inst <= c_NOP_INST;
        end else if (i_load) begin
            if (i_bubble) begin
                r_pc   <= c_ZERO_WORD;
                r_inst <= c_NOP_INST;
            end else begin
                r_pc   <= i_word.pc;
                r_inst <= i_word.inst;
            end
        end
    end

    assign o_pc   = r_pc;
    assign o_inst = r_inst;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
//==============================================================================
// Module      : if_stage
// Description : MIPS instruction fetch with single-outstanding imem handshake,
//               stall hold buffer and delay-slot aware redirect.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_resp_pc;
    logic        r_redir_pend;
    logic [31:0] r_redir_tgt;
    if_word_t    r_hold;

    logic        w_redir;
    logic [31:0] w_tgt;
    logic        w_req;
    logic        w_bubble;
    if_word_t    w_word;

    assign w_redir = branch_flag_i && !stall_i;
    assign w_tgt   = align_word(branch_target_address_i);

    always_ff @(posedge clk or negedge rst) begin
        if (rst == c_RST_ENABLE) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: w_next_state = c_S_REQ;
            c_S_REQ:  if (imem_gnt_i) w_next_state = c_S_WAIT;
            c_S_WAIT: if (imem_rvalid_i) w_next_state = stall_i ? c_S_HOLD : c_S_REQ;
            c_S_HOLD: if (!stall_i) w_next_state = c_S_REQ;
            default:  w_next_state = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_req    = 1'b0;
        w_bubble = 1'b1;
        w_word   = '{pc: c_ZERO_WORD, inst: c_NOP_INST};
        case (r_state)
            c_S_REQ: w_req = 1'b1;
            c_S_WAIT: begin
                if (imem_rvalid_i) begin
                    w_bubble = 1'b0;
                    w_word   = '{pc: r_resp_pc, inst: imem_rdata_i};
                end
            end
            c_S_HOLD: begin
                w_bubble = 1'b0;
                w_word   = r_hold;
            end
            default: ;
        endcase
    end

    // In REQ the outstanding request is the delay slot, so a redirect there is
    // deferred to its grant; in WAIT/HOLD fetch_pc already points past it.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == c_RST_ENABLE) begin
            r_fetch_pc   <= align_word(RESET_PC);
            r_resp_pc    <= c_ZERO_WORD;
            r_redir_pend <= 1'b0;
            r_redir_tgt  <= c_ZERO_WORD;
            r_hold       <= '{pc: c_ZERO_WORD, inst: c_NOP_INST};
        end else begin
            case (r_state)
                c_S_REQ: begin
                    if (imem_gnt_i) begin
                        r_resp_pc    <= r_fetch_pc;
                        r_redir_pend <= 1'b0;
                        if (w_redir) begin
                            r_fetch_pc <= w_tgt;
                        end else if (r_redir_pend) begin
                            r_fetch_pc <= r_redir_tgt;
                        end else begin
                            r_fetch_pc <= r_fetch_pc + 32'd4;
                        end
                    end else if (w_redir) begin
                        r_redir_pend <= 1'b1;
                        r_redir_tgt  <= w_tgt;
                    end
                end
                c_S_WAIT: begin
                    if (w_redir) begin
                        r_fetch_pc <= w_tgt;
                    end
                    if (imem_rvalid_i && stall_i) begin
                        r_hold <= '{pc: r_resp_pc, inst: imem_rdata_i};
                    end
                end
                c_S_HOLD: begin
                    if (w_redir) begin
                        r_fetch_pc <= w_tgt;
                    end
                end
                default: ;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .i_load   (!stall_i),
        .i_bubble (w_bubble),
        .i_word   (w_word),
        .o_pc     (pc_o),
        .o_inst   (inst_o)
    );

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_fetch_pc;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
//==============================================================================
// Module      : tb_if_stage
// Description : Directed self-checking bench for if_stage.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;

    int checks   = 0;
    int failures = 0;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall_i                 (stall_i),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .imem_req_o              (imem_req_o),
        .imem_addr_o             (imem_addr_o),
        .imem_gnt_i              (imem_gnt_i),
        .imem_rvalid_i           (imem_rvalid_i),
        .imem_rdata_i            (imem_rdata_i),
        .pc_o                    (pc_o),
        .inst_o                  (inst_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        stall_i = 1'b0;
        branch_flag_i = 1'b0;
        branch_target_address_i = 32'h0;
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = 32'h0;

        step(); step();
        chk("rst_req",  {31'h0, imem_req_o}, 32'h0);
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_pc",   pc_o, 32'h0);
        chk("rst_inst", inst_o, 32'h0);

        rst = 1'b1;
        chk("idle_req", {31'h0, imem_req_o}, 32'h0);
        step();
        chk("req0", {31'h0, imem_req_o}, 32'h1);
        chk("addr0", imem_addr_o, 32'h0);

        // word 0x0
        imem_gnt_i = 1'b1;
        step();
        chk("wait0_req", {31'h0, imem_req_o}, 32'h0);
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hC000_0000;
        step();
        chk("w0_pc",   pc_o, 32'h0);
        chk("w0_inst", inst_o, 32'hC000_0000);
        chk("addr4",   imem_addr_o, 32'h4);
        chk("req4",    {31'h0, imem_req_o}, 32'h1);

        // word 0x4
        imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0;
        step();
        chk("bub1_inst", inst_o, 32'h0);
        chk("bub1_pc",   pc_o, 32'h0);
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hC000_0004;
        step();
        chk("w4_pc",   pc_o, 32'h4);
        chk("w4_inst", inst_o, 32'hC000_0004);
        chk("addr8",   imem_addr_o, 32'h8);

        // word 0x8 arrives under stall, stall held 3 cycles
        imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0;
        step();
        stall_i = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hC000_0008;
        step();
        chk("hold_req",  {31'h0, imem_req_o}, 32'h0);
        chk("hold_inst", inst_o, 32'h0);
        imem_rvalid_i = 1'b0; imem_rdata_i = 32'hDEAD_BEEF;
        step(); step();
        chk("hold3_req",  {31'h0, imem_req_o}, 32'h0);
        chk("hold3_pc",   pc_o, 32'h0);
        stall_i = 1'b0;
        step();
        chk("w8_pc",   pc_o, 32'h8);
        chk("w8_inst", inst_o, 32'hC000_0008);
        chk("addrC",   imem_addr_o, 32'hC);
        chk("reqC",    {31'h0, imem_req_o}, 32'h1);

        // words 0xC and 0x10 (branch)
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hC000_000C;
        step();
        chk("wC_inst", inst_o, 32'hC000_000C);
        imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0;
        step();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h1000_0040;
        step();
        chk("w10_pc", pc_o, 32'h10);
        chk("addr14", imem_addr_o, 32'h14);

        // redirect while delay-slot request 0x14 is ungranted
        imem_rvalid_i = 1'b0; branch_flag_i = 1'b1; branch_target_address_i = 32'h100;
        step();
        branch_flag_i = 1'b0; branch_target_address_i = 32'h0;
        chk("ds_addr_a", imem_addr_o, 32'h14);
        chk("ds_bub_pc", pc_o, 32'h0);
        step();
        chk("ds_addr_b", imem_addr_o, 32'h14);
        chk("ds_req_b",  {31'h0, imem_req_o}, 32'h1);
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hC000_0014;
        step();
        chk("ds_pc",    pc_o, 32'h14);
        chk("ds_inst",  inst_o, 32'hC000_0014);
        chk("tgt_addr", imem_addr_o, 32'h100);

        // branch under stall is ignored
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1; stall_i = 1'b1;
        branch_flag_i = 1'b1; branch_target_address_i = 32'h200;
        step();
        chk("stall_keep_pc", pc_o, 32'h14);
        branch_flag_i = 1'b0; stall_i = 1'b0; imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hC000_0100;
        step();
        chk("w100_pc",  pc_o, 32'h100);
        chk("seq_addr", imem_addr_o, 32'h104);

        // redirect coincident with rvalid in WAIT; target low bits forced to 0
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hC000_0104;
        branch_flag_i = 1'b1; branch_target_address_i = 32'h303;
        step();
        branch_flag_i = 1'b0; imem_rvalid_i = 1'b0;
        chk("co_pc",   pc_o, 32'h104);
        chk("co_inst", inst_o, 32'hC000_0104);
        chk("co_addr", imem_addr_o, 32'h300);

        // rvalid outside WAIT is ignored
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_0000;
        step();
        chk("stray_inst", inst_o, 32'h0);
        chk("stray_req",  {31'h0, imem_req_o}, 32'h1);

        // reset asserted mid-transaction in WAIT
        imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        chk("pre_rst_addr", imem_addr_o, 32'h304);
        rst = 1'b0;
        #1;
        chk("async_addr", imem_addr_o, 32'h0);
        chk("async_req",  {31'h0, imem_req_o}, 32'h0);
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_0304;
        step();
        chk("drop_inst", inst_o, 32'h0);
        chk("drop_pc",   pc_o, 32'h0);
        imem_rvalid_i = 1'b0;
        rst = 1'b1;
        step();
        chk("restart_req",  {31'h0, imem_req_o}, 32'h1);
        chk("restart_addr", imem_addr_o, 32'h0);
        chk("restart_inst", inst_o, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
